// File: rtl/hot_sequencer_if.sv
// hot_sequencer_if: microcode fetch, condition, interrupt and status signals
// shared between the sequencer (master) and the surrounding control logic
// (slave). Only clk and rst stay outside the bundle.
interface hot_sequencer_if #(
  parameter int NUM_ADR_BITS  = 8,
  parameter int STACK_DEPTH   = 4,
  parameter int NUM_COND      = 8,
  parameter int NUM_COND_BITS = 3,
  parameter int NUM_IRQ       = 4,
  parameter int LOOP_WIDTH    = 8
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic                            hlt;
  logic [NUM_COND-1:0]             cond;
  logic [2:0]                      op;
  logic [NUM_COND_BITS-1:0]        cond_sel;
  logic                            cond_inv;
  logic [NUM_ADR_BITS-1:0]         jadr;
  logic [NUM_IRQ-1:0]              irq;
  logic [NUM_IRQ*NUM_ADR_BITS-1:0] irq_vec;
  logic                            clr_err;
  logic [NUM_ADR_BITS-1:0]         address;
  logic                            in_isr;
  logic [NUM_IRQ-1:0]              irq_ack;
  logic [LVL_W-1:0]                stack_level;
  logic                            stk_ovf;
  logic                            stk_unf;

  modport master (
    input  hlt, cond, op, cond_sel, cond_inv, jadr, irq, irq_vec, clr_err,
    output address, in_isr, irq_ack, stack_level, stk_ovf, stk_unf
  );

  modport slave (
    output hlt, cond, op, cond_sel, cond_inv, jadr, irq, irq_vec, clr_err,
    input  address, in_isr, irq_ack, stack_level, stk_ovf, stk_unf
  );
endinterface

// File: rtl/hot_sequencer.sv
// hot_sequencer: microcode address sequencer with return stack, loop counter,
// wait-on-condition, sticky stack error flags and prioritised vectored
// interrupts. One instruction per cycle; the next address is registered.
// Interrupt logic is built only when HOT_SEQ_IRQ_EN is defined; otherwise
// irq/irq_vec are ignored, irq_ack and in_isr stay 0 and RTN is a plain pop.
module hot_sequencer #(
  parameter int NUM_ADR_BITS  = 8,
  parameter int STACK_DEPTH   = 4,
  parameter int NUM_COND      = 8,
  parameter int NUM_COND_BITS = 3,
  parameter int NUM_IRQ       = 4,
  parameter int LOOP_WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  hot_sequencer_if.master  bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_BR    = 3'd2,
    OP_CALL  = 3'd3,
    OP_RTN   = 3'd4,
    OP_LDCNT = 3'd5,
    OP_DJNZ  = 3'd6,
    OP_WAIT  = 3'd7
  } op_e;

  logic [NUM_ADR_BITS-1:0] addr_q, addr_nxt, addr_inc;
  logic [LVL_W-1:0]        lvl_q, lvl_nxt, pop_lvl;
  logic [LOOP_WIDTH-1:0]   cnt_q, cnt_nxt, cnt_load;
  logic                    isr_q, isr_nxt;
  logic [LVL_W-1:0]        isr_lvl_q, isr_lvl_nxt;
  logic [NUM_IRQ-1:0]      ack_q, ack_nxt;
  logic                    ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic                    ovf_set, unf_set;
  logic [NUM_ADR_BITS-1:0] stack_mem [STACK_DEPTH];
  logic                    push_en;
  logic [NUM_ADR_BITS-1:0] push_data, top;
  logic [IDX_W-1:0]        wr_idx, top_idx;
  logic                    full, empty;
  logic                    c;
  op_e                     op_cur;
  logic                    irq_take;
  logic [NUM_IRQ-1:0]      irq_onehot;
  logic [NUM_ADR_BITS-1:0] irq_target;

  // Loop load value: jadr zero-extended or truncated to the counter width.
  if (LOOP_WIDTH > NUM_ADR_BITS) begin : g_cnt_ext
    always_comb cnt_load = {{(LOOP_WIDTH-NUM_ADR_BITS){1'b0}}, bus.jadr};
  end else begin : g_cnt_trunc
    always_comb cnt_load = bus.jadr[LOOP_WIDTH-1:0];
  end

  // Condition select, stack status and top-of-stack read.
  always_comb begin
    op_cur   = op_e'(bus.op);
    c        = ((32'(bus.cond_sel) < NUM_COND) ? bus.cond[bus.cond_sel] : 1'b0) ^ bus.cond_inv;
    addr_inc = addr_q + NUM_ADR_BITS'(1);
    full     = (lvl_q == LVL_W'(STACK_DEPTH));
    empty    = (lvl_q == '0);
    pop_lvl  = lvl_q - LVL_W'(1);
    wr_idx   = IDX_W'(lvl_q);
    top_idx  = IDX_W'(pop_lvl);
    top      = stack_mem[top_idx];
  end

`ifdef HOT_SEQ_IRQ_EN
  // Interrupt acceptance: lowest pending channel wins, one level deep only.
  always_comb begin
    irq_onehot = '0;
    irq_target = '0;
    irq_take   = (bus.irq != '0) && !isr_q && !bus.hlt && !full;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (bus.irq[k] && (irq_onehot == '0)) begin
        irq_onehot[k] = 1'b1;
        irq_target    = bus.irq_vec[k*NUM_ADR_BITS +: NUM_ADR_BITS];
      end
    end
  end
`else
  // Interrupts not built: never accept.
  always_comb begin
    irq_take   = 1'b0;
    irq_onehot = '0;
    irq_target = '0;
  end
`endif

  // Next-state decode; hlt freezes everything, an accepted interrupt
  // replaces the current instruction (which is re-executed on return).
  always_comb begin
    addr_nxt    = addr_q;
    lvl_nxt     = lvl_q;
    cnt_nxt     = cnt_q;
    isr_nxt     = isr_q;
    isr_lvl_nxt = isr_lvl_q;
    ack_nxt     = '0;
    push_en     = 1'b0;
    push_data   = addr_inc;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    ovf_nxt     = ovf_q;
    unf_nxt     = unf_q;
    if (!bus.hlt) begin
      if (irq_take) begin
        push_en     = 1'b1;
        push_data   = addr_q;
        lvl_nxt     = lvl_q + LVL_W'(1);
        addr_nxt    = irq_target;
        isr_nxt     = 1'b1;
        isr_lvl_nxt = lvl_q;
        ack_nxt     = irq_onehot;
      end else begin
        case (op_cur)
          OP_NEXT:  addr_nxt = addr_inc;
          OP_JMP:   addr_nxt = bus.jadr;
          OP_BR:    addr_nxt = c ? bus.jadr : addr_inc;
          OP_CALL: begin
            if (full) begin
              addr_nxt = addr_inc;
              ovf_set  = 1'b1;
            end else begin
              push_en  = 1'b1;
              lvl_nxt  = lvl_q + LVL_W'(1);
              addr_nxt = bus.jadr;
            end
          end
          OP_RTN: begin
            if (empty) begin
              addr_nxt = '0;
              unf_set  = 1'b1;
            end else begin
              addr_nxt = top;
              lvl_nxt  = pop_lvl;
              if (isr_q && (pop_lvl == isr_lvl_q)) isr_nxt = 1'b0;
            end
          end
          OP_LDCNT: begin
            cnt_nxt  = cnt_load;
            addr_nxt = addr_inc;
          end
          OP_DJNZ: begin
            if (cnt_q != '0) begin
              cnt_nxt  = cnt_q - LOOP_WIDTH'(1);
              addr_nxt = bus.jadr;
            end else begin
              addr_nxt = addr_inc;
            end
          end
          OP_WAIT:  addr_nxt = c ? addr_inc : addr_q;
          default:  addr_nxt = addr_inc;
        endcase
      end
      ovf_nxt = ovf_set | (ovf_q & ~bus.clr_err);
      unf_nxt = unf_set | (unf_q & ~bus.clr_err);
    end
  end

  // State registers and return-stack write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      lvl_q     <= '0;
      cnt_q     <= '0;
      isr_q     <= 1'b0;
      isr_lvl_q <= '0;
      ack_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      addr_q    <= addr_nxt;
      lvl_q     <= lvl_nxt;
      cnt_q     <= cnt_nxt;
      isr_q     <= isr_nxt;
      isr_lvl_q <= isr_lvl_nxt;
      ack_q     <= ack_nxt;
      ovf_q     <= ovf_nxt;
      unf_q     <= unf_nxt;
      if (push_en) stack_mem[wr_idx] <= push_data;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.address     = addr_q;
    bus.stack_level = lvl_q;
    bus.in_isr      = isr_q;
    bus.irq_ack     = ack_q;
    bus.stk_ovf     = ovf_q;
    bus.stk_unf     = unf_q;
  end
endmodule

// File: tb/tb_hot_sequencer.sv
// tb_hot_sequencer: directed tests for hot_sequencer driven from a small
// combinational microcode ROM indexed by the sequencer address.
module tb_hot_sequencer;
  localparam int A   = 8;
  localparam int SD  = 4;
  localparam int NC  = 8;
  localparam int NCB = 3;
  localparam int NI  = 4;
  localparam int LW  = 8;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                         RTN = 3'd4, LDCNT = 3'd5, DJNZ = 3'd6, WAITC = 3'd7;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  hot_sequencer_if #(.NUM_ADR_BITS(A), .STACK_DEPTH(SD), .NUM_COND(NC),
                     .NUM_COND_BITS(NCB), .NUM_IRQ(NI), .LOOP_WIDTH(LW)) bus ();

  hot_sequencer #(.NUM_ADR_BITS(A), .STACK_DEPTH(SD), .NUM_COND(NC),
                  .NUM_COND_BITS(NCB), .NUM_IRQ(NI), .LOOP_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0]     rom_op   [256];
  logic [NCB-1:0] rom_sel  [256];
  logic           rom_inv  [256];
  logic [A-1:0]   rom_jadr [256];

  assign bus.op       = rom_op[bus.address];
  assign bus.cond_sel = rom_sel[bus.address];
  assign bus.cond_inv = rom_inv[bus.address];
  assign bus.jadr     = rom_jadr[bus.address];

  task automatic set_rom(input int adr, input logic [2:0] op, input logic [NCB-1:0] sel,
                         input logic inv, input logic [A-1:0] j);
    rom_op[adr]   = op;
    rom_sel[adr]  = sel;
    rom_inv[adr]  = inv;
    rom_jadr[adr] = j;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) set_rom(i, NEXT, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.hlt     = 1'b0;
    bus.cond    = '0;
    bus.irq     = '0;
    bus.irq_vec = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.address !== 8'd0) $display("FAIL reset_addr: got %0h expected 0", bus.address);
    else passed++;
    total++;
    if (bus.stack_level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", bus.stack_level);
    else passed++;
    total++;
    if (bus.in_isr !== 1'b0) $display("FAIL reset_in_isr: got %0b expected 0", bus.in_isr);
    else passed++;
    total++;
    if (bus.irq_ack !== 4'b0000) $display("FAIL reset_irq_ack: got %0b expected 0", bus.irq_ack);
    else passed++;
    total++;
    if (bus.stk_ovf !== 1'b0) $display("FAIL reset_ovf: got %0b expected 0", bus.stk_ovf);
    else passed++;
    total++;
    if (bus.stk_unf !== 1'b0) $display("FAIL reset_unf: got %0b expected 0", bus.stk_unf);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_next_wrap();
    logic [A-1:0] exp;
    clear_rom();
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      step();
      exp = A'(i);
      total++;
      if (bus.address !== exp) $display("FAIL next_wrap[%0d]: got %0h expected %0h", i, bus.address, exp);
      else passed++;
    end
  endtask

  task automatic test_loop();
    logic [A-1:0] q[$];
    clear_rom();
    set_rom(10, LDCNT, '0, 1'b0, 8'd3);
    set_rom(12, DJNZ,  '0, 1'b0, 8'd11);
    set_rom(13, DJNZ,  '0, 1'b0, 8'd30);
    for (int i = 1; i <= 10; i++) q.push_back(A'(i));
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'd11);
      q.push_back(8'd12);
    end
    q.push_back(8'd13);
    q.push_back(8'd14);
    do_reset();
    for (int i = 0; i < q.size(); i++) begin
      step();
      total++;
      if (bus.address !== q[i]) $display("FAIL loop[%0d]: got %0h expected %0h", i, bus.address, q[i]);
      else passed++;
    end
  endtask

  task automatic test_stack();
    logic [A-1:0] ea [10];
    logic [2:0]   el [10];
    ea = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd41, 8'd31, 8'd21, 8'd11, 8'd1, 8'd0};
    el = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    clear_rom();
    set_rom(0,  CALL, '0, 1'b0, 8'd10);
    set_rom(10, CALL, '0, 1'b0, 8'd20);
    set_rom(20, CALL, '0, 1'b0, 8'd30);
    set_rom(30, CALL, '0, 1'b0, 8'd40);
    set_rom(40, CALL, '0, 1'b0, 8'd50);
    set_rom(41, RTN,  '0, 1'b0, '0);
    set_rom(31, RTN,  '0, 1'b0, '0);
    set_rom(21, RTN,  '0, 1'b0, '0);
    set_rom(11, RTN,  '0, 1'b0, '0);
    set_rom(1,  RTN,  '0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.address !== ea[i]) $display("FAIL stack_addr[%0d]: got %0h expected %0h", i, bus.address, ea[i]);
      else passed++;
      total++;
      if (bus.stack_level !== el[i]) $display("FAIL stack_level[%0d]: got %0d expected %0d", i, bus.stack_level, el[i]);
      else passed++;
      if (i == 4) begin
        total++;
        if (bus.stk_ovf !== 1'b1) $display("FAIL stack_ovf_set: got %0b expected 1", bus.stk_ovf);
        else passed++;
        total++;
        if (bus.stk_unf !== 1'b0) $display("FAIL stack_unf_clear: got %0b expected 0", bus.stk_unf);
        else passed++;
      end
    end
    total++;
    if (bus.stk_unf !== 1'b1) $display("FAIL stack_unf_set: got %0b expected 1", bus.stk_unf);
    else passed++;
    total++;
    if (bus.stk_ovf !== 1'b1) $display("FAIL stack_ovf_sticky: got %0b expected 1", bus.stk_ovf);
    else passed++;
    // clear flags, then clear and underflow in the same cycle
    set_rom(0, NEXT, '0, 1'b0, '0);
    bus.clr_err = 1'b1;
    step();
    total++;
    if ({bus.stk_ovf, bus.stk_unf} !== 2'b00) $display("FAIL clr_err: got %0b expected 00", {bus.stk_ovf, bus.stk_unf});
    else passed++;
    total++;
    if (bus.address !== 8'd1) $display("FAIL clr_err_addr: got %0h expected 1", bus.address);
    else passed++;
    step();
    total++;
    if ({bus.stk_ovf, bus.stk_unf} !== 2'b01) $display("FAIL clr_vs_set: got %0b expected 01", {bus.stk_ovf, bus.stk_unf});
    else passed++;
    total++;
    if (bus.address !== 8'd0) $display("FAIL unf_addr: got %0h expected 0", bus.address);
    else passed++;
    bus.clr_err = 1'b0;
  endtask

  task automatic test_wait();
    clear_rom();
    set_rom(5, WAITC, 3'd2, 1'b0, '0);
    set_rom(6, WAITC, 3'd2, 1'b1, '0);
    do_reset();
    repeat (5) step();
    total++;
    if (bus.address !== 8'd5) $display("FAIL wait_reach: got %0h expected 5", bus.address);
    else passed++;
    bus.cond = 8'hFB;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.address !== 8'd5) $display("FAIL wait_hold[%0d]: got %0h expected 5", i, bus.address);
      else passed++;
    end
    bus.hlt  = 1'b1;
    bus.cond = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.address !== 8'd5) $display("FAIL wait_hlt[%0d]: got %0h expected 5", i, bus.address);
      else passed++;
    end
    bus.hlt = 1'b0;
    step();
    total++;
    if (bus.address !== 8'd6) $display("FAIL wait_release: got %0h expected 6", bus.address);
    else passed++;
    step();
    total++;
    if (bus.address !== 8'd6) $display("FAIL wait_inv_hold: got %0h expected 6", bus.address);
    else passed++;
    bus.cond = 8'h00;
    step();
    total++;
    if (bus.address !== 8'd7) $display("FAIL wait_inv_go: got %0h expected 7", bus.address);
    else passed++;
    bus.hlt = 1'b1;
    step();
    total++;
    if (bus.address !== 8'd7) $display("FAIL hlt_next: got %0h expected 7", bus.address);
    else passed++;
    bus.hlt = 1'b0;
    step();
    total++;
    if (bus.address !== 8'd8) $display("FAIL hlt_resume: got %0h expected 8", bus.address);
    else passed++;
  endtask

  task automatic test_branch();
    clear_rom();
    set_rom(0,   BR,  3'd1, 1'b0, 8'd100);
    set_rom(100, BR,  3'd1, 1'b0, 8'd50);
    set_rom(101, JMP, '0,   1'b0, 8'd200);
    set_rom(200, BR,  3'd7, 1'b1, 8'd33);
    do_reset();
    bus.cond = 8'h02;
    step();
    total++;
    if (bus.address !== 8'd100) $display("FAIL br_taken: got %0h expected 64", bus.address);
    else passed++;
    bus.cond = 8'h00;
    step();
    total++;
    if (bus.address !== 8'd101) $display("FAIL br_not_taken: got %0h expected 65", bus.address);
    else passed++;
    step();
    total++;
    if (bus.address !== 8'd200) $display("FAIL jmp: got %0h expected c8", bus.address);
    else passed++;
    step();
    total++;
    if (bus.address !== 8'd33) $display("FAIL br_inv: got %0h expected 21", bus.address);
    else passed++;
  endtask

  task automatic test_irq();
    clear_rom();
    set_rom(8'h40, RTN, '0, 1'b0, '0);
    set_rom(8'h70, RTN, '0, 1'b0, '0);
    do_reset();
    bus.irq_vec = {8'h60, 8'h50, 8'h40, 8'h70};
    repeat (20) step();
    total++;
    if (bus.address !== 8'd20) $display("FAIL irq_reach: got %0h expected 14", bus.address);
    else passed++;
`ifdef HOT_SEQ_IRQ_EN
    bus.irq = 4'b0110;
    step();
    total++;
    if (bus.address !== 8'h40) $display("FAIL irq_vector: got %0h expected 40", bus.address);
    else passed++;
    total++;
    if (bus.irq_ack !== 4'b0010) $display("FAIL irq_ack: got %0b expected 0010", bus.irq_ack);
    else passed++;
    total++;
    if (bus.in_isr !== 1'b1) $display("FAIL irq_in_isr: got %0b expected 1", bus.in_isr);
    else passed++;
    total++;
    if (bus.stack_level !== 3'd1) $display("FAIL irq_level: got %0d expected 1", bus.stack_level);
    else passed++;
    step();
    total++;
    if (bus.address !== 8'd20) $display("FAIL irq_return: got %0h expected 14", bus.address);
    else passed++;
    total++;
    if (bus.in_isr !== 1'b0) $display("FAIL irq_isr_clear: got %0b expected 0", bus.in_isr);
    else passed++;
    total++;
    if (bus.irq_ack !== 4'b0000) $display("FAIL irq_ack_pulse: got %0b expected 0000", bus.irq_ack);
    else passed++;
    bus.irq = 4'b0000;
    step();
    total++;
    if (bus.address !== 8'd21) $display("FAIL irq_resume: got %0h expected 15", bus.address);
    else passed++;
    bus.hlt = 1'b1;
    bus.irq = 4'b1001;
    step();
    total++;
    if ({bus.address, bus.irq_ack} !== {8'd21, 4'b0000}) $display("FAIL irq_hlt: got %0h expected 150", {bus.address, bus.irq_ack});
    else passed++;
    bus.hlt = 1'b0;
    step();
    total++;
    if ({bus.address, bus.irq_ack} !== {8'h70, 4'b0001}) $display("FAIL irq_prio0: got %0h expected 701", {bus.address, bus.irq_ack});
    else passed++;
    bus.irq = 4'b0000;
`else
    bus.irq = 4'hF;
    step();
    total++;
    if (bus.address !== 8'd21) $display("FAIL irq_off_addr: got %0h expected 15", bus.address);
    else passed++;
    total++;
    if ({bus.irq_ack, bus.in_isr} !== 5'b0) $display("FAIL irq_off_ack: got %0b expected 0", {bus.irq_ack, bus.in_isr});
    else passed++;
    step();
    total++;
    if ({bus.address, bus.irq_ack} !== {8'd22, 4'b0000}) $display("FAIL irq_off_next: got %0h expected 160", {bus.address, bus.irq_ack});
    else passed++;
    bus.irq = 4'h0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_next_wrap();
    test_loop();
    test_stack();
    test_wait();
    test_branch();
    test_irq();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hot_sequencer.md
# hot_sequencer

Parametrised next-generation microcode sequencer for the hot algorithmic state machine. It generates the microcode address each cycle from the current instruction's opcode and jump field and a selected condition input. It adds a hardware loop counter, a wait-on-condition opcode, N prioritised vectored interrupt channels, and stack overflow/underflow detection. It sits between the microcode memory (combinational read, addressed by `address`) and the control and datapath logic, replacing the separate next-address, stack and control blocks.

## Interface
- NUM_ADR_BITS, 8, microcode address width
- STACK_DEPTH, 4, return-stack entries (≥1)
- NUM_COND, 8, condition inputs
- NUM_COND_BITS, 3, condition select width (2^NUM_COND_BITS ≥ NUM_COND)
- NUM_IRQ, 4, interrupt channels
- LOOP_WIDTH, 8, loop counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- hlt  in  1  freeze: address, stack, counter and flags hold; no interrupt accepted
- cond  in  NUM_COND  condition inputs
- op  in  3  opcode of instruction at `address`
- cond_sel  in  NUM_COND_BITS  condition index
- cond_inv  in  1  invert selected condition
- jadr  in  NUM_ADR_BITS  jump target / loop load value
- irq  in  NUM_IRQ  level interrupt requests
- irq_vec  in  NUM_IRQ*NUM_ADR_BITS  vector per channel, channel k at [k*NUM_ADR_BITS +: NUM_ADR_BITS]
- clr_err  in  1  clears sticky error flags
- address  out  NUM_ADR_BITS  current microcode address
- in_isr  out  1  interrupt in service
- irq_ack  out  NUM_IRQ  one-hot acceptance pulse
- stack_level  out  $clog2(STACK_DEPTH+1)  occupied entries
- stk_ovf, stk_unf  out  1  sticky overflow / underflow flags

## Operation
- c = cond[cond_sel] ^ cond_inv; cond_sel ≥ NUM_COND reads 0.
- Opcodes: 0 NEXT (address+1); 1 JMP (jadr); 2 BR (c ? jadr : +1); 3 CALL (push address+1, go jadr); 4 RTN (pop into address); 5 LDCNT (cnt ← jadr truncated/zero-extended to LOOP_WIDTH, +1); 6 DJNZ (cnt≠0 ? cnt−1 and go jadr : +1); 7 WAIT (c ? +1 : hold).
- Address +1 wraps from 2^NUM_ADR_BITS−1 to 0.
- CALL with stack full: no push, no jump, advance +1, set stk_ovf.
- RTN with stack empty: address ← 0, set stk_unf.
- Interrupt eligible when irq≠0, !in_isr, !hlt, stack not full. Lowest index wins. On accept: current instruction suppressed (no counter/stack/op effect); push current address; address ← irq_vec[k]; in_isr ← 1; record isr_level = stack_level before the push.
- RTN that pops the stack back to isr_level clears in_isr. No nesting.
- clr_err clears both flags; if an error event occurs in the same cycle, the set wins.

## Timing
- Reset values: address 0, stack_level 0, counter 0, in_isr 0, irq_ack 0, stk_ovf 0, stk_unf 0.
- Microcode fields are valid combinationally in the same cycle as `address`. The next address is registered, giving one instruction per cycle.
- irq_ack[k] is high for exactly one cycle, the cycle in which address = irq_vec[k].
- Interrupt latency: irq sampled high at edge N, so the vector appears after edge N.
- hlt takes priority over everything except reset. Releasing hlt resumes without loss.
- Reset asserted mid-operation clears all state immediately, asynchronously.

## Configuration
- HOT_SEQ_IRQ_EN defined: interrupt logic is present as above.
- HOT_SEQ_IRQ_EN undefined: irq and irq_vec are ignored, irq_ack is tied to 0, in_isr is tied to 0, and RTN behaves as a plain pop.

## Test plan
- Reset then all NEXT ops, NUM_ADR_BITS=8 → address 0,1,…,255,0.
- LDCNT jadr=3 at 10, DJNZ jadr=11 at 12 → body 11–12 runs four times, then address 13, counter 0.
- STACK_DEPTH=4, five nested CALLs → fifth advances +1, stk_ovf=1, stack_level=4. Then five RTNs → fifth yields address 0 and stk_unf=1.
- irq=4'b0110 at address 20, vectors 0x40/0x50 → address 0x40, irq_ack=4'b0010 for one cycle, in_isr=1. RTN → address 20, in_isr=0.
- WAIT with cond_sel=2 and cond[2]=0 for 5 cycles, then 1 → address holds 5 cycles, then +1. hlt during WAIT holds regardless of cond.
- Without HOT_SEQ_IRQ_EN, irq=4'hF → no vector taken, irq_ack stays 0.
